// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register word addresses and bus width.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;

    typedef logic [GPIO_MAX_WIDTH-1:0] gpio_word_t;
    typedef logic [2:0]                gpio_addr_t;

    localparam gpio_addr_t GPIO_DATA_OUT = 3'd0;
    localparam gpio_addr_t GPIO_DIR      = 3'd1;
    localparam gpio_addr_t GPIO_DATA_IN  = 3'd2;
    localparam gpio_addr_t GPIO_IRQ_EN   = 3'd3;
    localparam gpio_addr_t GPIO_IRQ_STAT = 3'd4;
    localparam gpio_addr_t GPIO_OUT_SET  = 3'd5;
    localparam gpio_addr_t GPIO_OUT_CLR  = 3'd6;
    localparam gpio_addr_t GPIO_OUT_TGL  = 3'd7;

endpackage

// File: rtl/gpio_if.sv
// Simple peripheral register bus: write/read strobes, word address, 32-bit data.
interface gpio_if;
    import gpio_pkg::*;

    logic       we;
    logic       re;
    gpio_addr_t addr;
    gpio_word_t wdata;
    gpio_word_t rdata;

    modport master (output we, output re, output addr, output wdata, input rdata);
    modport slave  (input we, input re, input addr, input wdata, output rdata);

endinterface

// File: rtl/gpio_sync.sv
// Multi-stage flop chain bringing asynchronous pin levels into the clk domain.
module gpio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Stage 0 captures the pin; each later stage shifts one step toward the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: direction, output data with atomic set/clear/toggle,
// synchronised inputs and sticky rising-edge interrupt status.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    gpio_if.slave            bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q,      dir_d;
    logic [WIDTH-1:0] irq_en_q,   irq_en_d;
    logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
    logic [WIDTH-1:0] prev_q;
    gpio_word_t       rdata_q,    rdata_d;

    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] w1c_mask;
    gpio_word_t       rd_val;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (gpio_in),
        .sync_o  (sync_w)
    );

    assign wdata_w = bus.wdata[WIDTH-1:0];
    assign rise_w  = sync_w & ~prev_q;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        w1c_mask   = '0;
        if (bus.we) begin
            case (bus.addr)
                GPIO_DATA_OUT: data_out_d = wdata_w;
                GPIO_DIR:      dir_d      = wdata_w;
                GPIO_IRQ_EN:   irq_en_d   = wdata_w;
                GPIO_IRQ_STAT: w1c_mask   = wdata_w;
                GPIO_OUT_SET:  data_out_d = data_out_q | wdata_w;
                GPIO_OUT_CLR:  data_out_d = data_out_q & ~wdata_w;
                GPIO_OUT_TGL:  data_out_d = data_out_q ^ wdata_w;
                default:       ;
            endcase
        end
        // A new edge outranks a same-cycle clear so no event is ever lost.
        irq_stat_d = (irq_stat_q & ~w1c_mask) | rise_w;
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            GPIO_DATA_OUT: rd_val[WIDTH-1:0] = data_out_q;
            GPIO_DIR:      rd_val[WIDTH-1:0] = dir_q;
            GPIO_DATA_IN:  rd_val[WIDTH-1:0] = sync_w;
            GPIO_IRQ_EN:   rd_val[WIDTH-1:0] = irq_en_q;
            GPIO_IRQ_STAT: rd_val[WIDTH-1:0] = irq_stat_q;
            default:       rd_val = '0;
        endcase
        rdata_d = bus.re ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            prev_q     <= '0;
            rdata_q    <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            prev_q     <= sync_w;
            rdata_q    <= rdata_d;
        end
    end

    assign gpio_out  = data_out_q;
    assign gpio_oe   = dir_q;
    assign irq       = |(irq_stat_q & irq_en_q);
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench: a 32-pin and an 8-pin controller share one stimulus stream.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out32, gpio_oe32;
    logic [7:0]  gpio_out8,  gpio_oe8;
    logic        irq32, irq8;

    int n_checks;
    int n_fail;
    logic [31:0] exp32_q [$];
    logic [31:0] exp8_q  [$];

    gpio_if bus32 ();
    gpio_if bus8 ();

    assign bus32.we = we;  assign bus32.re = re;  assign bus32.addr = addr;  assign bus32.wdata = wdata;
    assign bus8.we  = we;  assign bus8.re  = re;  assign bus8.addr  = addr;  assign bus8.wdata  = wdata;

    gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32.slave), .gpio_in(gpio_in),
        .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32)
    );

    gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8.slave), .gpio_in(gpio_in[7:0]),
        .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] r32, output logic [31:0] r8);
        @(negedge clk);
        re = 1'b1; addr = a;
        @(posedge clk); #1;
        re = 1'b0;
        r32 = bus32.rdata;
        r8  = bus8.rdata;
        $display("read  addr=%0d rdata32=0x%08h rdata8=0x%08h", a, r32, r8);
    endtask

    task automatic test_reset;
        logic [31:0] r32, r8, e;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (gpio_out32 !== 32'h0 || gpio_oe32 !== 32'h0 || irq32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h oe=%h irq=%b, expected all 0", gpio_out32, gpio_oe32, irq32);
        end
        for (int i = 0; i < 5; i++) begin
            exp32_q.push_back(32'h0);
            bus_read(3'(i), r32, r8);
            e = exp32_q.pop_front();
            n_checks++;
            if (r32 !== e) begin
                n_fail++;
                $display("FAIL reset_read addr %0d: got 0x%08h expected 0x%08h", i, r32, e);
            end
        end
    endtask

    task automatic test_atomic;
        logic [2:0]  ops [4] = '{GPIO_DATA_OUT, GPIO_OUT_SET, GPIO_OUT_CLR, GPIO_OUT_TGL};
        logic [31:0] dat [4] = '{32'h1234FF3F, 32'h000000C0, 32'h0000FF00, 32'h00000001};
        logic [31:0] res [4] = '{32'h1234FF3F, 32'h1234FFFF, 32'h123400FF, 32'h123400FE};
        logic [31:0] r32, r8, e;
        for (int i = 0; i < 4; i++) begin
            exp32_q.push_back(res[i]);
            bus_write(ops[i], dat[i]);
            n_checks++;
            if (gpio_out32 !== res[i]) begin
                n_fail++;
                $display("FAIL atomic_out op %0d: got 0x%08h expected 0x%08h", i, gpio_out32, res[i]);
            end
            e = res[i];
            n_checks++;
            if (gpio_out8 !== e[7:0]) begin
                n_fail++;
                $display("FAIL atomic_out8 op %0d: got 0x%02h expected 0x%02h", i, gpio_out8, e[7:0]);
            end
            bus_read(GPIO_DATA_OUT, r32, r8);
            e = exp32_q.pop_front();
            n_checks++;
            if (r32 !== e) begin
                n_fail++;
                $display("FAIL atomic_read op %0d: got 0x%08h expected 0x%08h", i, r32, e);
            end
        end
    endtask

    task automatic test_width;
        logic [31:0] r32, r8, e;
        exp32_q.push_back(32'h111FABCD);
        exp8_q.push_back(32'h000000CD);
        bus_write(GPIO_DATA_OUT, 32'h111FABCD);
        n_checks++;
        if (gpio_out8 !== 8'hCD) begin
            n_fail++;
            $display("FAIL width_out8: got 0x%02h expected 0xcd", gpio_out8);
        end
        bus_read(GPIO_DATA_OUT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL width_read32: got 0x%08h expected 0x%08h", r32, e); end
        e = exp8_q.pop_front();
        n_checks++;
        if (r8 !== e) begin n_fail++; $display("FAIL width_read8: got 0x%08h expected 0x%08h", r8, e); end
        bus_write(GPIO_DIR, 32'hFFFFF0A5);
        n_checks++;
        if (gpio_oe8 !== 8'hA5 || gpio_oe32 !== 32'hFFFFF0A5) begin
            n_fail++;
            $display("FAIL width_oe: got oe8=0x%02h oe32=0x%08h expected 0xa5 / 0xfffff0a5", gpio_oe8, gpio_oe32);
        end
        bus_write(GPIO_DIR, 32'h0);
        // Write-only and read-only addresses
        bus_write(GPIO_DATA_IN, 32'hFFFFFFFF);
        for (int a = 2; a < 8; a++) begin
            if (a == 3 || a == 4) continue;
            exp32_q.push_back(32'h0);
            exp8_q.push_back(32'h0);
            bus_read(3'(a), r32, r8);
            e = exp32_q.pop_front();
            n_checks++;
            if (r32 !== e) begin n_fail++; $display("FAIL unused_read32 addr %0d: got 0x%08h expected 0x%08h", a, r32, e); end
            e = exp8_q.pop_front();
            n_checks++;
            if (r8 !== e) begin n_fail++; $display("FAIL unused_read8 addr %0d: got 0x%08h expected 0x%08h", a, r8, e); end
        end
    endtask

    task automatic test_irq;
        logic [31:0] r32, r8, e;
        bus_write(GPIO_IRQ_EN, 32'h1);
        // Pin rises before edge k; read DATA_IN continuously across k, k+1, k+2
        @(negedge clk);
        gpio_in[0] = 1'b1; re = 1'b1; addr = GPIO_DATA_IN;
        @(posedge clk); #1;
        exp32_q.push_back(32'h0);
        @(posedge clk); #1;
        e = exp32_q.pop_front();
        n_checks++;
        if (bus32.rdata !== e || irq32 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: got data_in=0x%08h irq=%b expected 0x%08h irq=0", bus32.rdata, irq32, e);
        end
        exp32_q.push_back(32'h1);
        @(posedge clk); #1;
        re = 1'b0;
        e = exp32_q.pop_front();
        n_checks++;
        if (bus32.rdata !== e) begin n_fail++; $display("FAIL data_in_sync: got 0x%08h expected 0x%08h", bus32.rdata, e); end
        n_checks++;
        if (irq32 !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b expected 1", irq32); end
        exp32_q.push_back(32'h1);
        bus_read(GPIO_IRQ_STAT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL irq_stat_set: got 0x%08h expected 0x%08h", r32, e); end
        bus_write(GPIO_IRQ_STAT, 32'h1);
        n_checks++;
        if (irq32 !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b expected 0", irq32); end
        // Edge on a disabled pin still latches status but keeps irq low
        @(negedge clk);
        gpio_in[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (irq32 !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq32); end
        exp32_q.push_back(32'h2);
        bus_read(GPIO_IRQ_STAT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL irq_stat_masked: got 0x%08h expected 0x%08h", r32, e); end
        bus_write(GPIO_IRQ_STAT, 32'h2);
        // Falling edges set nothing
        @(negedge clk);
        gpio_in[1:0] = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        exp32_q.push_back(32'h0);
        bus_read(GPIO_IRQ_STAT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e || irq32 !== 1'b0) begin
            n_fail++;
            $display("FAIL falling_edge: got stat=0x%08h irq=%b expected 0x%08h irq=0", r32, irq32, e);
        end
    endtask

    task automatic test_collision;
        logic [31:0] r32, r8, e;
        @(negedge clk);
        gpio_in[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        // The W1C lands on the same edge that latches the new rising edge
        @(negedge clk);
        we = 1'b1; addr = GPIO_IRQ_STAT; wdata = 32'h1;
        @(posedge clk); #1;
        we = 1'b0;
        $display("write addr=4 data=0x00000001 (collides with edge)");
        n_checks++;
        if (irq32 !== 1'b1) begin n_fail++; $display("FAIL collision_irq: got %b expected 1", irq32); end
        exp32_q.push_back(32'h1);
        bus_read(GPIO_IRQ_STAT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL collision_stat: got 0x%08h expected 0x%08h", r32, e); end
        bus_write(GPIO_IRQ_STAT, 32'h1);
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_rw_same;
        logic [31:0] r32, r8, e;
        bus_write(GPIO_DATA_OUT, 32'h5);
        exp32_q.push_back(32'h5);
        @(negedge clk);
        we = 1'b1; re = 1'b1; addr = GPIO_DATA_OUT; wdata = 32'hA;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        $display("write+read addr=0 data=0x0000000a rdata32=0x%08h", bus32.rdata);
        e = exp32_q.pop_front();
        n_checks++;
        if (bus32.rdata !== e) begin n_fail++; $display("FAIL rw_same_rdata: got 0x%08h expected 0x%08h", bus32.rdata, e); end
        n_checks++;
        if (gpio_out32 !== 32'hA) begin n_fail++; $display("FAIL rw_same_out: got 0x%08h expected 0x0000000a", gpio_out32); end
        exp32_q.push_back(32'hA);
        bus_read(GPIO_DATA_OUT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL rw_same_next: got 0x%08h expected 0x%08h", r32, e); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [3] = '{GPIO_DATA_OUT, GPIO_OUT_SET, GPIO_OUT_TGL};
        logic [31:0] dat [3] = '{32'h0, 32'hF0, 32'hFF};
        logic [31:0] res [3] = '{32'h0, 32'hF0, 32'h0F};
        logic [31:0] r32, r8, e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we = 1'b1; addr = ops[i]; wdata = dat[i];
            @(posedge clk); #1;
            $display("write addr=%0d data=0x%08h (back-to-back)", ops[i], dat[i]);
            n_checks++;
            if (gpio_out32 !== res[i]) begin
                n_fail++;
                $display("FAIL b2b_out step %0d: got 0x%08h expected 0x%08h", i, gpio_out32, res[i]);
            end
        end
        we = 1'b0;
        // rdata must still hold the last read value since re stayed low
        n_checks++;
        if (bus32.rdata !== 32'hA) begin n_fail++; $display("FAIL rdata_hold: got 0x%08h expected 0x0000000a", bus32.rdata); end
        exp32_q.push_back(32'h0F);
        bus_read(GPIO_DATA_OUT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL b2b_read: got 0x%08h expected 0x%08h", r32, e); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r32, r8, e;
        bus_write(GPIO_DATA_OUT, 32'h3C);
        bus_write(GPIO_DIR, 32'hFF);
        bus_read(GPIO_DATA_OUT, r32, r8);
        @(negedge clk);
        reset = 1'b1; we = 1'b1; re = 1'b1; addr = GPIO_DATA_OUT; wdata = 32'hFF;
        @(posedge clk); #1;
        reset = 1'b0; we = 1'b0; re = 1'b0;
        $display("reset with write addr=0 data=0x000000ff");
        n_checks++;
        if (gpio_out32 !== 32'h0 || gpio_oe32 !== 32'h0 || bus32.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got out=0x%08h oe=0x%08h rdata=0x%08h expected all 0", gpio_out32, gpio_oe32, bus32.rdata);
        end
        exp32_q.push_back(32'h0);
        bus_read(GPIO_DATA_OUT, r32, r8);
        e = exp32_q.pop_front();
        n_checks++;
        if (r32 !== e) begin n_fail++; $display("FAIL reset_mid_read: got 0x%08h expected 0x%08h", r32, e); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        we       = 1'b0;
        re       = 1'b0;
        addr     = 3'd0;
        wdata    = 32'h0;
        gpio_in  = 32'h0;
        test_reset;
        test_atomic;
        test_width;
        test_irq;
        test_collision;
        test_rw_same;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
